// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: length codes, reset PC and FSM state encoding.
package fetch_seq_ctrl_pkg;

    localparam int PC_PLUS_WIDTH = 2;

    localparam logic [PC_PLUS_WIDTH-1:0] PC_PLUS_2 = 2'b00;
    localparam logic [PC_PLUS_WIDTH-1:0] PC_PLUS_4 = 2'b01;
    localparam logic [PC_PLUS_WIDTH-1:0] PC_PLUS_6 = 2'b10;
    localparam logic [PC_PLUS_WIDTH-1:0] PC_PLUS_8 = 2'b11;

    localparam logic [31:0] DEFAULT_START_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        KILL = 3'd2,
        OUT  = 3'd3,
        LEN  = 3'd4
    } fetchState_e;

    // Byte distance to the next sequential instruction for a Decode length code.
    function automatic logic [3:0] lenIncrement(input logic [PC_PLUS_WIDTH-1:0] code);
        case (code)
            PC_PLUS_2: lenIncrement = 4'd2;
            PC_PLUS_4: lenIncrement = 4'd4;
            PC_PLUS_6: lenIncrement = 4'd6;
            default:   lenIncrement = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect priority mux: a branch from EX beats an exception from Ctrl; targets are halfword aligned.
module fetch_redirect_sel #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  branchFlag,
    input  logic [ADDR_WIDTH-1:0] branchPc,
    input  logic                  excpFlag,
    input  logic [ADDR_WIDTH-1:0] excpPc,
    output logic                  redirectValid,
    output logic [ADDR_WIDTH-1:0] redirectPc
);

    always_comb begin
        redirectValid = branchFlag | excpFlag;
        redirectPc    = (branchFlag ? branchPc : excpPc) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs one Icache request at a time and
// hands each instruction to IFID, draining any request that a redirect has made stale.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(DEFAULT_START_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  EX_BranchFlag,
    input  logic [ADDR_WIDTH-1:0] EX_BranchPC,
    input  logic                  Ctrl_ExcpFlag,
    input  logic [ADDR_WIDTH-1:0] Ctrl_ExcpPC,
    input  logic                  Decode_Valid,
    input  logic [1:0]            Decode_NextPC,
    output logic                  Fetch_IcacheReq,
    output logic [ADDR_WIDTH-1:0] Fetch_IcacheAddr,
    input  logic                  Icache_Ack,
    input  logic [INST_WIDTH-1:0] Icache_Inst,
    output logic                  Fetch_Valid,
    output logic [ADDR_WIDTH-1:0] Fetch_PC,
    output logic [INST_WIDTH-1:0] Fetch_Inst
);

    fetchState_e           state, nextState;
    logic [ADDR_WIDTH-1:0] pc, pcNext;
    logic [ADDR_WIDTH-1:0] pendPc, pendPcNext;
    logic [ADDR_WIDTH-1:0] fetchPcReg, fetchPcNext;
    logic [INST_WIDTH-1:0] instReg, instNext;
    logic                  reqReg, reqNext;
    logic                  validReg, validNext;
    logic                  redirectValid;
    logic [ADDR_WIDTH-1:0] redirectPc;
    logic                  ackSeen;

    fetch_redirect_sel #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) redirectSel (
        .branchFlag   (EX_BranchFlag),
        .branchPc     (EX_BranchPC),
        .excpFlag     (Ctrl_ExcpFlag),
        .excpPc       (Ctrl_ExcpPC),
        .redirectValid(redirectValid),
        .redirectPc   (redirectPc)
    );

    // An Ack only counts against a request we are actually driving, so stray pulses are harmless.
    assign ackSeen = Icache_Ack & reqReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            BOOT: nextState = REQ;
            REQ: begin
                if (ackSeen && !redirectValid)       nextState = OUT;
                else if (reqReg && !ackSeen && redirectValid) nextState = KILL;
            end
            KILL: if (ackSeen) nextState = REQ;
            OUT: begin
                if (redirectValid) nextState = REQ;
                else if (!Stall)   nextState = LEN;
            end
            LEN: if (redirectValid || Decode_Valid) nextState = REQ;
            default: nextState = BOOT;
        endcase
    end

    // Fetch_IcacheAddr is the pc itself, so pc only moves when no handshake is open.
    always_comb begin
        pcNext      = pc;
        pendPcNext  = pendPc;
        fetchPcNext = fetchPcReg;
        instNext    = instReg;
        case (state)
            BOOT: if (redirectValid) pcNext = redirectPc;
            REQ: begin
                if (!reqReg) begin
                    if (redirectValid) pcNext = redirectPc;
                end else if (ackSeen) begin
                    if (redirectValid) begin
                        pcNext = redirectPc;
                    end else begin
                        fetchPcNext = pc;
                        instNext    = Icache_Inst;
                    end
                end else if (redirectValid) begin
                    pendPcNext = redirectPc;
                end
            end
            KILL: begin
                if (ackSeen)            pcNext     = redirectValid ? redirectPc : pendPc;
                else if (redirectValid) pendPcNext = redirectPc;
            end
            OUT: if (redirectValid) pcNext = redirectPc;
            LEN: begin
                if (redirectValid)     pcNext = redirectPc;
                else if (Decode_Valid) pcNext = fetchPcReg + ADDR_WIDTH'(lenIncrement(Decode_NextPC));
            end
            default: ;
        endcase
        // Req always drops for a cycle after an Ack so the next request shows a fresh rising edge.
        reqNext   = ((nextState == REQ) || (nextState == KILL)) && !ackSeen;
        validNext = (nextState == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= START_PC;
            pendPc     <= START_PC;
            fetchPcReg <= START_PC;
            instReg    <= '0;
            reqReg     <= 1'b0;
            validReg   <= 1'b0;
        end else begin
            pc         <= pcNext;
            pendPc     <= pendPcNext;
            fetchPcReg <= fetchPcNext;
            instReg    <= instNext;
            reqReg     <= reqNext;
            validReg   <= validNext;
        end
    end

    assign Fetch_IcacheReq  = reqReg;
    assign Fetch_IcacheAddr = pc;
    assign Fetch_Valid      = validReg;
    assign Fetch_PC         = fetchPcReg;
    assign Fetch_Inst       = instReg;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] START = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall, EX_BranchFlag, Ctrl_ExcpFlag, Decode_Valid, Icache_Ack;
    logic [31:0] EX_BranchPC, Ctrl_ExcpPC, Icache_Inst;
    logic [1:0]  Decode_NextPC;
    logic        Fetch_IcacheReq, Fetch_Valid;
    logic [31:0] Fetch_IcacheAddr, Fetch_PC, Fetch_Inst;

    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;

    // Reference model of what IFID and the Icache should observe.
    logic        mReq, mValid, mBooting, mKilled, mAwaitLen;
    logic [31:0] mAddr, mPc, mInst, mPend;

    // Icache responder knobs
    int          age = 0;
    int          latency = 1;
    logic        randomLatency = 1'b0;
    logic        fixedData = 1'b1;
    logic [31:0] fixedInst = 32'h0000_0013;

    fetch_seq_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Stall           (Stall),
        .EX_BranchFlag   (EX_BranchFlag),
        .EX_BranchPC     (EX_BranchPC),
        .Ctrl_ExcpFlag   (Ctrl_ExcpFlag),
        .Ctrl_ExcpPC     (Ctrl_ExcpPC),
        .Decode_Valid    (Decode_Valid),
        .Decode_NextPC   (Decode_NextPC),
        .Fetch_IcacheReq (Fetch_IcacheReq),
        .Fetch_IcacheAddr(Fetch_IcacheAddr),
        .Icache_Ack      (Icache_Ack),
        .Icache_Inst     (Icache_Inst),
        .Fetch_Valid     (Fetch_Valid),
        .Fetch_PC        (Fetch_PC),
        .Fetch_Inst      (Fetch_Inst)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    task automatic modelReset();
        mReq = 1'b0; mValid = 1'b0; mBooting = 1'b1; mKilled = 1'b0; mAwaitLen = 1'b0;
        mAddr = START; mPc = START; mInst = 32'h0; mPend = START;
    endtask

    // Advances the model across one rising edge using the inputs that were presented.
    task automatic modelStep();
        logic        redir, ack;
        logic [31:0] tgt;
        redir = EX_BranchFlag || Ctrl_ExcpFlag;
        tgt   = EX_BranchFlag ? EX_BranchPC : Ctrl_ExcpPC;
        tgt[0] = 1'b0;
        ack   = Icache_Ack && mReq;
        if (mBooting) begin
            mBooting = 1'b0;
            if (redir) mAddr = tgt;
            mReq = 1'b1;
        end else if (mValid) begin
            if (redir) begin
                mValid = 1'b0; mAddr = tgt; mReq = 1'b1;
            end else if (!Stall) begin
                mValid = 1'b0; mAwaitLen = 1'b1;
            end
        end else if (mAwaitLen) begin
            if (redir) begin
                mAwaitLen = 1'b0; mAddr = tgt; mReq = 1'b1;
            end else if (Decode_Valid) begin
                mAwaitLen = 1'b0;
                mAddr = mPc + 32'(2 * (int'(Decode_NextPC) + 1));
                mReq = 1'b1;
            end
        end else if (!mReq) begin
            if (redir) mAddr = tgt;
            mReq = 1'b1;
        end else if (ack) begin
            mReq = 1'b0;
            if (redir || mKilled) begin
                mAddr = redir ? tgt : mPend;
                mKilled = 1'b0;
            end else begin
                mValid = 1'b1; mPc = mAddr; mInst = Icache_Inst;
            end
        end else if (redir) begin
            mKilled = 1'b1; mPend = tgt;
        end
    endtask

    task automatic checkOutput();
        checkOne("req",   32'(Fetch_IcacheReq), 32'(mReq));
        checkOne("addr",  Fetch_IcacheAddr,     mAddr);
        checkOne("valid", 32'(Fetch_Valid),     32'(mValid));
        checkOne("pc",    Fetch_PC,             mPc);
        checkOne("inst",  Fetch_Inst,           mInst);
    endtask

    // Icache environment: acks `latency` cycles after Req rises.
    task automatic icacheRespond();
        if (Fetch_IcacheReq) begin
            age++;
        end else begin
            age = 0;
            if (randomLatency) latency = $urandom_range(1, 4);
        end
        Icache_Ack  = Fetch_IcacheReq && (age == latency + 1);
        Icache_Inst = fixedData ? fixedInst : $urandom;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
        cycleNo++;
        checkOutput();
        icacheRespond();
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] bpc,
                                 input logic ex, input logic [31:0] epc,
                                 input logic dv, input logic [1:0] code);
        Stall = stall; EX_BranchFlag = br; EX_BranchPC = bpc;
        Ctrl_ExcpFlag = ex; Ctrl_ExcpPC = epc;
        Decode_Valid = dv; Decode_NextPC = code;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00);
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles && !Fetch_Valid; i++) stepCycle();
        checkOne(name, 32'(Fetch_Valid), 32'd1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        Icache_Ack = 1'b0;
        age = 0;
        idle();
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOne({tag, " req"},   32'(Fetch_IcacheReq), 32'd0);
        checkOne({tag, " addr"},  Fetch_IcacheAddr,     START);
        checkOne({tag, " valid"}, 32'(Fetch_Valid),     32'd0);
        checkOne({tag, " pc"},    Fetch_PC,             START);
        checkOne({tag, " inst"},  Fetch_Inst,           32'h0);
    endtask

    initial begin
        int reqCycle;
        idle();
        Icache_Ack = 1'b0;
        Icache_Inst = 32'h0;
        modelReset();
        for (int i = 0; i < 3; i++) stepCycle();
        checkResetOutputs("reset");

        // Scenario 1: first fetch after reset
        rst_n = 1'b1;
        stepCycle();
        checkOne("t1 req", 32'(Fetch_IcacheReq), 32'd1);
        checkOne("t1 addr", Fetch_IcacheAddr, 32'h8000_0000);
        reqCycle = cycleNo;
        waitValid("t1 valid", 10);
        checkOne("t1 req2valid", 32'(cycleNo - reqCycle), 32'd2);
        checkOne("t1 pc", Fetch_PC, 32'h8000_0000);
        checkOne("t1 inst", Fetch_Inst, 32'h0000_0013);

        // Scenario 2: sequential PCs from length codes
        stepCycle();
        checkOne("t2 accepted", 32'(Fetch_Valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b01);
        stepCycle();
        idle();
        checkOne("t2 addr +4", Fetch_IcacheAddr, 32'h8000_0004);
        waitValid("t2 valid", 10);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11);
        stepCycle();
        idle();
        checkOne("t2 addr +8", Fetch_IcacheAddr, 32'h8000_000C);

        // Scenario 3: stall holds the presented instruction
        Stall = 1'b1;
        waitValid("t3 valid", 10);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOne("t3 hold valid", 32'(Fetch_Valid), 32'd1);
            checkOne("t3 hold pc", Fetch_PC, 32'h8000_000C);
            checkOne("t3 hold req", 32'(Fetch_IcacheReq), 32'd0);
        end
        Stall = 1'b0;
        stepCycle();
        checkOne("t3 released", 32'(Fetch_Valid), 32'd0);
        stepCycle();
        checkOne("t3 len waits", 32'(Fetch_IcacheReq), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b00);
        stepCycle();
        idle();
        checkOne("t3 addr +2", Fetch_IcacheAddr, 32'h8000_000E);

        // Scenario 4: branch during a slow request is drained
        doReset();
        latency = 3;
        stepCycle();
        checkOne("t4 addr", Fetch_IcacheAddr, 32'h8000_0000);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 2'b00);
        stepCycle();
        idle();
        checkOne("t4 kill req", 32'(Fetch_IcacheReq), 32'd1);
        checkOne("t4 kill addr", Fetch_IcacheAddr, 32'h8000_0000);
        stepCycle();
        checkOne("t4 ack addr", Fetch_IcacheAddr, 32'h8000_0000);
        stepCycle();
        checkOne("t4 drop valid", 32'(Fetch_Valid), 32'd0);
        checkOne("t4 gap req", 32'(Fetch_IcacheReq), 32'd0);
        stepCycle();
        checkOne("t4 new req", 32'(Fetch_IcacheReq), 32'd1);
        checkOne("t4 new addr", Fetch_IcacheAddr, 32'h8000_0100);

        // Scenario 5: branch beats exception; target bit0 cleared
        latency = 1;
        waitValid("t5 valid", 10);
        checkOne("t5 pc", Fetch_PC, 32'h8000_0100);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 2'b11);
        stepCycle();
        idle();
        checkOne("t5 priority", Fetch_IcacheAddr, 32'h0000_0200);
        waitValid("t5 valid2", 10);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0101, 1'b0, 2'b00);
        stepCycle();
        idle();
        checkOne("t5 bit0", Fetch_IcacheAddr, 32'h8000_0100);

        // Scenario 6: PC wrap, then async reset while draining
        waitValid("t6 valid", 10);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 2'b00);
        stepCycle();
        idle();
        waitValid("t6 valid2", 10);
        checkOne("t6 pc", Fetch_PC, 32'hFFFF_FFFE);
        stepCycle();
        latency = 3;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11);
        stepCycle();
        idle();
        checkOne("t6 wrap", Fetch_IcacheAddr, 32'h0000_0006);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 2'b00);
        stepCycle();
        idle();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("t6 async");
        Icache_Ack = 1'b0;
        age = 0;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        Icache_Ack = 1'b1;
        stepCycle();
        checkOne("t6 late ack valid", 32'(Fetch_Valid), 32'd0);
        checkOne("t6 boot addr", Fetch_IcacheAddr, 32'h8000_0000);

        // Randomized traffic against the model
        randomLatency = 1'b1;
        fixedData = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 499) == 0) doReset();
            r = $urandom_range(0, 99);
            applyStimulus($urandom_range(0, 9) < 3, r < 6, $urandom, (r >= 3) && (r < 10), $urandom,
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
